// File: rtl/frame_responder.sv
// Ethernet payload responder: captures a gap-terminated RX frame into a byte buffer and
// transmits a padded echo/zero reply. Define FRAME_RESPONDER_CSUM_EN to enable the reply checksum.
module frame_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int MIN_PAYLOAD = 46,
  parameter int GAP_CYCLES  = 4,
  parameter int ECHO        = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_send,
  output logic        o_done,
  input  logic [7:0]  i_rdata,
  input  logic        i_rready,
  output logic        o_rreq,
  output logic [7:0]  o_wdata,
  input  logic        i_wready,
  output logic        o_wvalid,
  output logic        o_ovf,
  output logic [15:0] o_frames,
  output logic [15:0] o_csum
);

  localparam int AW        = DEPTH_LOG2;
  localparam int DEPTH_CNT = 1 << DEPTH_LOG2;
  localparam int GW        = $clog2(GAP_CYCLES + 1);
  localparam logic [AW:0]   DEPTH    = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   MINLEN   = (AW+1)'(MIN_PAYLOAD);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [AW-1:0] ADDR0    = '0;

  typedef enum logic [2:0] {IDLE, RD_CAP, RD_GAP, TX_WAIT, TX_PULSE, DONE} state_t;

  state_t        state_q;
  logic [7:0]    mem_q [DEPTH_CNT];
  logic [AW:0]   rx_len_q, tx_len_q, idx_q;
  logic [GW-1:0] gap_q;
  logic          rreq_q, wvalid_q, done_q, ovf_q;
  logic [7:0]    wdata_q;
  logic [15:0]   frames_q;

  logic [AW:0]   idx_d, tx_len_d;
  logic [7:0]    wdata_first_d, wdata_next_d;
  logic          tx_start_d, last_byte_d;

  function automatic logic [AW:0] pad_len(input logic [AW:0] len);
    return (len < MINLEN) ? MINLEN : len;
  endfunction

  // Bytes past the captured length are padding and always go out as zero.
  function automatic logic [7:0] byte_sel(input logic [AW:0] i, input logic [AW:0] len,
                                          input logic [7:0] b);
    return (ECHO != 0 && i < len) ? b : 8'h00;
  endfunction

  always_comb begin
    idx_d         = idx_q + 1'b1;
    tx_len_d      = pad_len(rx_len_q);
    wdata_first_d = byte_sel('0, rx_len_q, mem_q[ADDR0]);
    wdata_next_d  = byte_sel(idx_d, rx_len_q, mem_q[idx_d[AW-1:0]]);
    tx_start_d    = !i_rready && ((state_q == IDLE && i_send) ||
                                  (state_q == RD_GAP && gap_q == GAP_LAST));
    last_byte_d   = (idx_q == tx_len_q - 1'b1);
  end

  always_ff @(posedge i_clk) begin
    if (state_q == RD_CAP && rx_len_q != DEPTH)
      mem_q[rx_len_q[AW-1:0]] <= i_rdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      rx_len_q <= '0;
      tx_len_q <= '0;
      idx_q    <= '0;
      gap_q    <= '0;
      rreq_q   <= 1'b0;
      wvalid_q <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wdata_q  <= '0;
      frames_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_rready) begin
            rreq_q   <= 1'b1;
            rx_len_q <= '0;
            ovf_q    <= 1'b0;
            state_q  <= RD_CAP;
          end else if (tx_start_d) begin
            tx_len_q <= tx_len_d;
            idx_q    <= '0;
            wdata_q  <= wdata_first_d;
            state_q  <= TX_WAIT;
          end
        end
        RD_CAP: begin
          if (rx_len_q != DEPTH) rx_len_q <= rx_len_q + 1'b1;
          else                   ovf_q    <= 1'b1;
          rreq_q  <= 1'b0;
          gap_q   <= '0;
          state_q <= RD_GAP;
        end
        RD_GAP: begin
          if (i_rready) begin
            rreq_q  <= 1'b1;
            state_q <= RD_CAP;
          end else if (tx_start_d) begin
            tx_len_q <= tx_len_d;
            idx_q    <= '0;
            wdata_q  <= wdata_first_d;
            state_q  <= TX_WAIT;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        TX_WAIT: begin
          if (i_wready) begin
            wvalid_q <= 1'b1;
            state_q  <= TX_PULSE;
          end
        end
        TX_PULSE: begin
          wvalid_q <= 1'b0;
          if (last_byte_d) begin
            done_q   <= 1'b1;
            frames_q <= frames_q + 16'd1;
            state_q  <= DONE;
          end else begin
            idx_q   <= idx_d;
            wdata_q <= wdata_next_d;
            state_q <= TX_WAIT;
          end
        end
        DONE: begin
          idx_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FRAME_RESPONDER_CSUM_EN
  logic [15:0] acc_q, csum_q, word_d;
  logic [16:0] sum_d;

  // Even byte indices are the high half of a big-endian word.
  always_comb begin
    word_d = idx_q[0] ? {8'h00, wdata_q} : {wdata_q, 8'h00};
    sum_d  = {1'b0, acc_q} + {1'b0, word_d};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q  <= '0;
      csum_q <= '0;
    end else begin
      if (tx_start_d)
        acc_q <= '0;
      else if (state_q == TX_WAIT && i_wready)
        acc_q <= sum_d[15:0] + {15'b0, sum_d[16]};
      if (state_q == TX_PULSE && last_byte_d)
        csum_q <= ~acc_q;
    end
  end

  assign o_csum = csum_q;
`else
  assign o_csum = '0;
`endif

  assign o_rreq   = rreq_q;
  assign o_wvalid = wvalid_q;
  assign o_done   = done_q;
  assign o_ovf    = ovf_q;
  assign o_wdata  = wdata_q;
  assign o_frames = frames_q;

endmodule
